// File: rtl/adc_measure_responder_if.sv
// Handshake and result bus between the AZ/sample sequencer (master) and the
// conversion responder (slave).
interface adc_measure_responder_if;
    logic        adc_measure_trig;
    logic [23:0] aperture_cycles;
    logic        adc_measure_valid;
    logic [23:0] count_up;
    logic [23:0] count_down;
    logic [23:0] count_rundown;
    logic        rundown_dir;
    logic        overflow;

    modport master (
        output adc_measure_trig,
        output aperture_cycles,
        input  adc_measure_valid,
        input  count_up,
        input  count_down,
        input  count_rundown,
        input  rundown_dir,
        input  overflow
    );

    modport slave (
        input  adc_measure_trig,
        input  aperture_cycles,
        output adc_measure_valid,
        output count_up,
        output count_down,
        output count_rundown,
        output rundown_dir,
        output overflow
    );
endinterface

// File: rtl/adc_measure_responder.sv
// Charge-balance conversion responder: integrator reset, fixed-period modulation,
// comparator-terminated rundown, then latched results with a valid flag.
module adc_measure_responder #(
    parameter int RESET_N     = 2000,
    parameter int MOD_N       = 200,
    parameter int RUNDOWN_MAX = 4000
) (
    input  logic                          clk,
    input  logic                          reset,
    adc_measure_responder_if.slave        bus,
    input  logic                          cmpr_val,
    output logic [1:0]                    refmux,
    output logic                          sigmux,
    output logic [1:0]                    monitor
);
    localparam logic [23:0] L_RESET_LOAD = 24'(RESET_N - 1);
    localparam logic [23:0] L_MOD_LAST   = 24'(MOD_N - 1);
    localparam logic [23:0] L_RD_LAST    = 24'(RUNDOWN_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_INTEG, S_RUNDOWN, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic        r_cs_meta, r_cs;
    logic [23:0] r_timer, r_phase, r_cyc, r_aper;
    logic [23:0] r_up, r_down, r_rd;
    logic        r_ref_neg, r_dir, r_ovf;
    logic        r_valid;
    logic [23:0] r_res_up, r_res_down, r_res_rd;
    logic        r_res_dir, r_res_ovf;

    logic w_trig, w_reset_done, w_cyc_start, w_cyc_end, w_last_cyc, w_rd_stop, w_rd_sat;

    assign w_trig       = bus.adc_measure_trig;
    assign w_reset_done = (r_timer == 24'd0);
    assign w_cyc_start  = (r_phase == 24'd0);
    assign w_cyc_end    = (r_phase == L_MOD_LAST);
    assign w_last_cyc   = (r_cyc == 24'd0);
    assign w_rd_stop    = (r_cs != r_dir);
    assign w_rd_sat     = (r_rd == L_RD_LAST);

    assign bus.adc_measure_valid = r_valid;
    assign bus.count_up          = r_res_up;
    assign bus.count_down        = r_res_down;
    assign bus.count_rundown     = r_res_rd;
    assign bus.rundown_dir       = r_res_dir;
    assign bus.overflow          = r_res_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The reference choice is visible on refmux in the very clock it is made,
    // so every modulation cycle sees the same reference for all MOD_N clocks.
    always_comb begin
        w_state_next = r_state;
        refmux       = 2'b00;
        sigmux       = 1'b0;
        monitor      = 2'b00;
        case (r_state)
            S_IDLE: ;
            S_RESET: begin
                refmux = 2'b11;
                if (w_reset_done) w_state_next = S_INTEG;
            end
            S_INTEG: begin
                sigmux     = 1'b1;
                monitor[0] = w_cyc_start;
                if (w_cyc_start) refmux = r_cs ? 2'b10 : 2'b01;
                else             refmux = r_ref_neg ? 2'b10 : 2'b01;
                if (w_cyc_end && w_last_cyc) w_state_next = S_RUNDOWN;
            end
            S_RUNDOWN: begin
                monitor[1] = 1'b1;
                refmux     = r_dir ? 2'b10 : 2'b01;
                if (w_rd_stop || w_rd_sat) w_state_next = S_DONE;
            end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_trig) w_state_next = S_RESET;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_meta  <= 1'b0;
            r_cs       <= 1'b0;
            r_timer    <= 24'd0;
            r_phase    <= 24'd0;
            r_cyc      <= 24'd0;
            r_aper     <= 24'd0;
            r_up       <= 24'd0;
            r_down     <= 24'd0;
            r_rd       <= 24'd0;
            r_ref_neg  <= 1'b0;
            r_dir      <= 1'b0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_res_up   <= 24'd0;
            r_res_down <= 24'd0;
            r_res_rd   <= 24'd0;
            r_res_dir  <= 1'b0;
            r_res_ovf  <= 1'b0;
        end else begin
            r_cs_meta <= cmpr_val;
            r_cs      <= r_cs_meta;
            // A trigger always wins, including on the completion edge.
            if (w_trig) begin
                r_timer <= L_RESET_LOAD;
                r_aper  <= (bus.aperture_cycles == 24'd0) ? 24'd1 : bus.aperture_cycles;
                r_phase <= 24'd0;
                r_up    <= 24'd0;
                r_down  <= 24'd0;
                r_rd    <= 24'd0;
                r_ovf   <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_RESET: begin
                        r_timer <= r_timer - 24'd1;
                        if (w_reset_done) begin
                            r_cyc   <= r_aper - 24'd1;
                            r_phase <= 24'd0;
                        end
                    end
                    S_INTEG: begin
                        if (w_cyc_start) begin
                            r_ref_neg <= r_cs;
                            if (r_cs) r_down <= r_down + 24'd1;
                            else      r_up   <= r_up + 24'd1;
                        end
                        if (w_cyc_end) begin
                            r_phase <= 24'd0;
                            r_cyc   <= r_cyc - 24'd1;
                            if (w_last_cyc) r_dir <= r_cs;
                        end else begin
                            r_phase <= r_phase + 24'd1;
                        end
                    end
                    S_RUNDOWN: begin
                        if (!w_rd_stop) begin
                            r_rd <= r_rd + 24'd1;
                            if (w_rd_sat) r_ovf <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_res_up   <= r_up;
                        r_res_down <= r_down;
                        r_res_rd   <= r_rd;
                        r_res_dir  <= r_dir;
                        r_res_ovf  <= r_ovf;
                        r_valid    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_measure_responder.sv
// Scenario bench for adc_measure_responder: expected results queued at trigger
// time, popped and compared when valid rises.
module tb_adc_measure_responder;
    localparam int RESET_N     = 10;
    localparam int MOD_N       = 8;
    localparam int RUNDOWN_MAX = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmpr_val;
    logic [1:0] refmux;
    logic       sigmux;
    logic [1:0] monitor;

    adc_measure_responder_if bus();

    adc_measure_responder #(
        .RESET_N(RESET_N), .MOD_N(MOD_N), .RUNDOWN_MAX(RUNDOWN_MAX)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .cmpr_val(cmpr_val),
        .refmux(refmux), .sigmux(sigmux), .monitor(monitor)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [73:0] res;
        int          vedge;
    } exp_t;
    exp_t sb[$];

    function automatic logic [73:0] pack_res(int u, int d, int r, bit dir, bit ovf);
        return {u[23:0], d[23:0], r[23:0], dir, ovf};
    endfunction

    function automatic logic [73:0] obs();
        return {bus.count_up, bus.count_down, bus.count_rundown, bus.rundown_dir, bus.overflow};
    endfunction

    task automatic tick_to(input int e);
        while (cyc < e) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic fire(input logic [23:0] ap, output int n);
        @(posedge clk); #1;
        bus.aperture_cycles  = ap;
        bus.adc_measure_trig = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        bus.adc_measure_trig = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.adc_measure_valid === 1'b1) begin
                e = cyc;
                break;
            end
        end
    endtask

    task automatic push_exp(input logic [73:0] res, input int vedge);
        exp_t x;
        x.res   = res;
        x.vedge = vedge;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        total++; if (bus.adc_measure_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.adc_measure_valid); end
        total++; if (refmux !== 2'b00) begin bad++; $display("FAIL reset_refmux: got %b want 00", refmux); end
        total++; if (sigmux !== 1'b0) begin bad++; $display("FAIL reset_sigmux: got %b want 0", sigmux); end
        total++; if (monitor !== 2'b00) begin bad++; $display("FAIL reset_monitor: got %b want 00", monitor); end
        total++; if (obs() !== pack_res(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_results: got %h want 0", obs()); end
        $display("test_reset: checked idle outputs after 100 clocks");
    endtask

    task automatic test_alternating();
        int n, e, v;
        exp_t y;
        cmpr_val = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        fire(24'd4, n);
        push_exp(pack_res(2, 2, 7, 1, 0), n + RESET_N + 4 * MOD_N + 7 + 2);
        total++; if (bus.adc_measure_valid !== 1'b0) begin bad++; $display("FAIL alt_valid_after_trig: got %b want 0", bus.adc_measure_valid); end
        tick_to(n + 2);
        total++; if ({refmux, sigmux} !== 3'b110) begin bad++; $display("FAIL alt_reset_mux: got %b want 110", {refmux, sigmux}); end
        tick_to(n + RESET_N);
        total++; if ({monitor, refmux, sigmux} !== 5'b01011) begin bad++; $display("FAIL alt_integ_start: got %b want 01011", {monitor, refmux, sigmux}); end
        for (int k = 1; k < 4; k++) begin
            tick_to(n + RESET_N + MOD_N * k - 4);
            cmpr_val = (k % 2 == 1);
        end
        e = n + RESET_N + 4 * MOD_N;
        tick_to(e + 1);
        total++; if ({monitor, refmux, sigmux} !== 5'b10100) begin bad++; $display("FAIL alt_rundown_mux: got %b want 10100", {monitor, refmux, sigmux}); end
        tick_to(e + 5);
        cmpr_val = 1'b0;
        wait_valid(200, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL alt_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL alt_results: got %h want %h", obs(), y.res); end
        $display("test_alternating: valid at edge %0d, results %h", v, obs());
    endtask

    task automatic test_stuck_low();
        int n, e, v;
        exp_t y;
        cmpr_val = 1'b0;
        fire(24'd5, n);
        e = n + RESET_N + 5 * MOD_N;
        push_exp(pack_res(5, 0, 37, 0, 0), e + 35 + 4);
        total++; if (bus.adc_measure_valid !== 1'b0) begin bad++; $display("FAIL low_valid_after_trig: got %b want 0", bus.adc_measure_valid); end
        tick_to(e + 35);
        cmpr_val = 1'b1;
        wait_valid(200, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL low_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL low_results: got %h want %h", obs(), y.res); end
        $display("test_stuck_low: valid at edge %0d, results %h", v, obs());
    endtask

    task automatic test_overflow();
        int n, v;
        exp_t y;
        cmpr_val = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        fire(24'd2, n);
        push_exp(pack_res(0, 2, RUNDOWN_MAX, 1, 1), n + RESET_N + 2 * MOD_N + RUNDOWN_MAX + 1);
        wait_valid(RUNDOWN_MAX + 200, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL ovf_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL ovf_results: got %h want %h", obs(), y.res); end
        $display("test_overflow: valid at edge %0d, results %h", v, obs());
    endtask

    task automatic test_abort();
        int n1, n2, e2, v;
        exp_t y;
        logic [73:0] prior;
        prior = pack_res(0, 2, RUNDOWN_MAX, 1, 1);
        cmpr_val = 1'b0;
        fire(24'd3, n1);
        total++; if (bus.adc_measure_valid !== 1'b0) begin bad++; $display("FAIL abort_valid_after_trig: got %b want 0", bus.adc_measure_valid); end
        tick_to(n1 + RESET_N + MOD_N + 3);
        fire(24'd0, n2);
        e2 = n2 + RESET_N + MOD_N;
        push_exp(pack_res(1, 0, 5, 0, 0), e2 + 3 + 4);
        tick_to(e2 + 3);
        total++; if ({bus.adc_measure_valid, obs()} !== {1'b0, prior}) begin bad++; $display("FAIL abort_held: got %h want %h", {bus.adc_measure_valid, obs()}, {1'b0, prior}); end
        cmpr_val = 1'b1;
        wait_valid(400, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL abort_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL abort_results: got %h want %h", obs(), y.res); end
        $display("test_abort: valid at edge %0d, results %h", v, obs());
    endtask

    task automatic test_back_to_back();
        int n, e, vd, v;
        exp_t y;
        cmpr_val = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        fire(24'd1, n);
        e  = n + RESET_N + MOD_N;
        vd = e + 4;
        tick_to(e);
        cmpr_val = 1'b1;
        tick_to(vd - 1);
        bus.aperture_cycles  = 24'd1;
        bus.adc_measure_trig = 1'b1;
        @(posedge clk); #1;
        bus.adc_measure_trig = 1'b0;
        total++; if ({bus.adc_measure_valid, obs()} !== {1'b0, pack_res(1, 0, 5, 0, 0)}) begin bad++; $display("FAIL b2b_done_edge: got %h want %h", {bus.adc_measure_valid, obs()}, {1'b0, pack_res(1, 0, 5, 0, 0)}); end
        e = vd + RESET_N + MOD_N;
        push_exp(pack_res(0, 1, 4, 1, 0), e + 6);
        tick_to(e + 2);
        cmpr_val = 1'b0;
        wait_valid(200, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL b2b_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL b2b_results: got %h want %h", obs(), y.res); end
        $display("test_back_to_back: valid at edge %0d, results %h", v, obs());
    endtask

    task automatic test_async_reset();
        int n, e, v;
        exp_t y;
        cmpr_val = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        fire(24'd1, n);
        tick_to(n + RESET_N + MOD_N + 10);
        total++; if ({monitor, refmux} !== 4'b1010) begin bad++; $display("FAIL arst_in_rundown: got %b want 1010", {monitor, refmux}); end
        #3 reset = 1'b1;
        #1;
        total++; if ({bus.adc_measure_valid, refmux, sigmux, monitor} !== 6'b0) begin bad++; $display("FAIL arst_outputs: got %b want 000000", {bus.adc_measure_valid, refmux, sigmux, monitor}); end
        total++; if (obs() !== pack_res(0, 0, 0, 0, 0)) begin bad++; $display("FAIL arst_results: got %h want 0", obs()); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        cmpr_val = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        fire(24'd2, n);
        e = n + RESET_N + 2 * MOD_N;
        push_exp(pack_res(2, 0, 2, 0, 0), e + 4);
        tick_to(e);
        cmpr_val = 1'b1;
        wait_valid(200, v);
        y = sb.pop_front();
        total++; if (v !== y.vedge) begin bad++; $display("FAIL arst_valid_edge: got %0d want %0d", v, y.vedge); end
        total++; if (obs() !== y.res) begin bad++; $display("FAIL arst_results_after: got %h want %h", obs(), y.res); end
        $display("test_async_reset: valid at edge %0d, results %h", v, obs());
    endtask

    initial begin
        bus.adc_measure_trig = 1'b0;
        bus.aperture_cycles  = 24'd0;
        cmpr_val             = 1'b0;
        reset                = 1'b1;
        test_reset();
        test_alternating();
        test_stuck_low();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
